// File: rtl/fft_pkg.sv
// Shared types and butterfly address helper for the radix-2 DIT FFT control path.
// Used by the sequencer RTL and by anything that needs the same address mapping.
package fft_pkg;

    localparam int MAX_LOG2_N = 16;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } fsm_state_t;

    typedef struct packed {
        logic [MAX_LOG2_N-1:0] a_idx;
        logic [MAX_LOG2_N-1:0] b_idx;
        logic [MAX_LOG2_N-1:0] tw_idx;
    } bfly_addr_t;

    // Butterfly k of stage s: operands sit half = 2^s apart inside groups of 2*half.
    function automatic bfly_addr_t bfly_addr(input logic [4:0] log2_n,
                                             input logic [4:0] s,
                                             input logic [MAX_LOG2_N-1:0] k);
        logic [MAX_LOG2_N-1:0] half;
        logic [MAX_LOG2_N-1:0] pos;
        logic [MAX_LOG2_N-1:0] grp;
        bfly_addr_t r;
        half     = MAX_LOG2_N'(1) << s;
        pos      = k & (half - MAX_LOG2_N'(1));
        grp      = k >> s;
        r.a_idx  = (grp << (s + 5'd1)) | pos;
        r.b_idx  = r.a_idx | half;
        r.tw_idx = pos << (log2_n - 5'd1 - s);
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with asynchronous flush; carries write-back
// strobe and addresses alongside the compute-unit pipeline.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/fft_butterfly_sequencer.sv
// Stage/butterfly walker for an in-place radix-2 DIT FFT: issues operand and
// twiddle reads, and replays them as write-back addresses after the pipeline.
module fft_butterfly_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N     = 10,
    parameter int RD_LATENCY = 1,
    parameter int CU_LATENCY = 14
) (
    input  logic                      clk,
    input  logic                      areset_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [LOG2_N-1:0]         rd_addr_a,
    output logic [LOG2_N-1:0]         rd_addr_b,
    output logic [LOG2_N-2:0]         tw_addr,
    output logic                      wr_en,
    output logic [LOG2_N-1:0]         wr_addr_a,
    output logic [LOG2_N-1:0]         wr_addr_b,
    output logic [$clog2(LOG2_N)-1:0] stage
);

    localparam int TOTAL_LAT = RD_LATENCY + CU_LATENCY;
    localparam int KW        = LOG2_N - 1;
    localparam int SW        = $clog2(LOG2_N);
    localparam int CW        = $clog2(TOTAL_LAT + 1);
    localparam int DLW       = 1 + 2 * LOG2_N;

    localparam logic [KW-1:0] K_LAST      = '1;
    localparam logic [SW-1:0] S_LAST      = SW'(LOG2_N - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(TOTAL_LAT - 1);
    localparam logic [CW-1:0] FINISH_LAST = CW'(TOTAL_LAT);

    fsm_state_t    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cnt_d   = '0;
                    state_d = (s_q == S_LAST) ? FINISH : DRAIN;
                end
            end
            // Hold reads until the stage's last result has been written back.
            DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ISSUE;
                    s_d     = s_q + 1'b1;
                    k_d     = '0;
                end
            end
            FINISH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FINISH_LAST) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE) && !done;
    assign stage = s_q;

    bfly_addr_t addr;
    logic       unused_addr_bits;

    always_comb addr = bfly_addr(5'(LOG2_N), 5'(s_q), MAX_LOG2_N'(k_q));

    assign unused_addr_bits = ^addr;

    // Addresses are forced to zero outside read slots so idle write-back slots stay clean.
    assign rd_addr_a = rd_en ? addr.a_idx[LOG2_N-1:0]  : '0;
    assign rd_addr_b = rd_en ? addr.b_idx[LOG2_N-1:0]  : '0;
    assign tw_addr   = rd_en ? addr.tw_idx[LOG2_N-2:0] : '0;

    logic [DLW-1:0] wb;

    fft_delay_line #(
        .WIDTH(DLW),
        .DEPTH(TOTAL_LAT)
    ) u_wb_delay (
        .clk     (clk),
        .areset_n(areset_n),
        .din     ({rd_en, rd_addr_a, rd_addr_b}),
        .dout    (wb)
    );

    assign {wr_en, wr_addr_a, wr_addr_b} = wb;

endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Bench for fft_butterfly_sequencer: an 8-point instance checked cycle by cycle
// and a 1024-point instance checked by scoreboard against a schedule model.
module tb_fft_butterfly_sequencer;

    logic clk = 1'b0;
    logic areset_n = 1'b0;
    logic start_s = 1'b0;
    logic start_l = 1'b0;

    always #5 clk = ~clk;

    // 8-point instance
    logic       busy_s, done_s, rd_en_s, wr_en_s;
    logic [2:0] rd_addr_a_s, rd_addr_b_s, wr_addr_a_s, wr_addr_b_s;
    logic [1:0] tw_addr_s;
    logic [1:0] stage_s;

    fft_butterfly_sequencer #(.LOG2_N(3), .RD_LATENCY(1), .CU_LATENCY(4)) dut_s (
        .clk(clk), .areset_n(areset_n), .start(start_s),
        .busy(busy_s), .done(done_s), .rd_en(rd_en_s),
        .rd_addr_a(rd_addr_a_s), .rd_addr_b(rd_addr_b_s), .tw_addr(tw_addr_s),
        .wr_en(wr_en_s), .wr_addr_a(wr_addr_a_s), .wr_addr_b(wr_addr_b_s),
        .stage(stage_s)
    );

    // 1024-point instance
    logic       busy_l, done_l, rd_en_l, wr_en_l;
    logic [9:0] rd_addr_a_l, rd_addr_b_l, wr_addr_a_l, wr_addr_b_l;
    logic [8:0] tw_addr_l;
    logic [3:0] stage_l;

    fft_butterfly_sequencer #(.LOG2_N(10), .RD_LATENCY(1), .CU_LATENCY(14)) dut_l (
        .clk(clk), .areset_n(areset_n), .start(start_l),
        .busy(busy_l), .done(done_l), .rd_en(rd_en_l),
        .rd_addr_a(rd_addr_a_l), .rd_addr_b(rd_addr_b_l), .tw_addr(tw_addr_l),
        .wr_en(wr_en_l), .wr_addr_a(wr_addr_a_l), .wr_addr_b(wr_addr_b_l),
        .stage(stage_l)
    );

    typedef struct {
        int          cyc;
        int          s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tw;
    } op_t;

    op_t rd_q[$];
    op_t wr_q[$];
    int  model_done;
    int  compared = 0;
    int  mismatched = 0;

    // Schedule from the FFT definition: each stage pairs points span/2 apart inside
    // blocks of span, twiddle exponent j*N/span, one butterfly per cycle, then a
    // pipeline-length pause before the next stage (or before completion).
    task automatic build_model(input int log2n, input int tl);
        int n, c, span;
        rd_q.delete();
        wr_q.delete();
        n = 1 << log2n;
        c = 1;
        for (int s = 0; s < log2n; s++) begin
            span = 2 << s;
            for (int g = 0; g < n / span; g++) begin
                for (int j = 0; j < span / 2; j++) begin
                    op_t op;
                    op.cyc = c;
                    op.s   = s;
                    op.a   = 16'(g * span + j);
                    op.b   = 16'(g * span + j + span / 2);
                    op.tw  = 16'(j * (n / span));
                    rd_q.push_back(op);
                    op.cyc = c + tl;
                    wr_q.push_back(op);
                    c++;
                end
            end
            c += tl;
        end
        model_done = wr_q[$].cyc + 1;
    endtask

    task automatic test_reset;
        areset_n = 1'b0;
        start_s  = 1'b0;
        start_l  = 1'b0;
        #12;
        compared++;
        if ({rd_en_s, wr_en_s, busy_s, done_s} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b want 0000", {rd_en_s, wr_en_s, busy_s, done_s});
        end
        compared++;
        if ({rd_addr_a_s, rd_addr_b_s, tw_addr_s, wr_addr_a_s, wr_addr_b_s, stage_s} !== 16'b0) begin
            mismatched++;
            $display("FAIL reset_addrs: got %h want 0",
                     {rd_addr_a_s, rd_addr_b_s, tw_addr_s, wr_addr_a_s, wr_addr_b_s, stage_s});
        end
        compared++;
        if ({rd_en_l, wr_en_l, busy_l, done_l} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_large: got %b want 0000", {rd_en_l, wr_en_l, busy_l, done_l});
        end
        @(negedge clk);
        areset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Full 8-point transform; start is additionally pulsed at cycle 'glitch' (ignored by design).
    task automatic test_transform(input int glitch, input int tail);
        int  ri = 0;
        int  wi = 0;
        logic exp_rd, exp_wr;
        build_model(3, 5);
        @(negedge clk);
        start_s = 1'b1;
        for (int c = 1; c <= model_done + tail; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            exp_rd = (ri < rd_q.size()) && (rd_q[ri].cyc == c);
            exp_wr = (wi < wr_q.size()) && (wr_q[wi].cyc == c);
            compared++;
            if (rd_en_s !== exp_rd) begin
                mismatched++;
                $display("FAIL rd_en c%0d: got %b want %b", c, rd_en_s, exp_rd);
            end
            if (exp_rd) begin
                compared++;
                if (rd_addr_a_s !== rd_q[ri].a[2:0] || rd_addr_b_s !== rd_q[ri].b[2:0] ||
                    tw_addr_s !== rd_q[ri].tw[1:0] || stage_s !== 2'(rd_q[ri].s)) begin
                    mismatched++;
                    $display("FAIL rd_addr c%0d: got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                             c, rd_addr_a_s, rd_addr_b_s, tw_addr_s, stage_s,
                             rd_q[ri].a, rd_q[ri].b, rd_q[ri].tw, rd_q[ri].s);
                end
                ri++;
            end
            compared++;
            if (wr_en_s !== exp_wr) begin
                mismatched++;
                $display("FAIL wr_en c%0d: got %b want %b", c, wr_en_s, exp_wr);
            end
            if (exp_wr) begin
                compared++;
                if (wr_addr_a_s !== wr_q[wi].a[2:0] || wr_addr_b_s !== wr_q[wi].b[2:0]) begin
                    mismatched++;
                    $display("FAIL wr_addr c%0d: got a=%0d b=%0d want a=%0d b=%0d",
                             c, wr_addr_a_s, wr_addr_b_s, wr_q[wi].a, wr_q[wi].b);
                end
                wi++;
            end
            compared++;
            if (done_s !== (c == model_done)) begin
                mismatched++;
                $display("FAIL done c%0d: got %b want %b", c, done_s, (c == model_done));
            end
            compared++;
            if (busy_s !== (c < model_done)) begin
                mismatched++;
                $display("FAIL busy c%0d: got %b want %b", c, busy_s, (c < model_done));
            end
            if (c == glitch) start_s = 1'b1;
        end
        start_s = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        start_s = 1'b1;
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            start_s = 1'b0;
        end
        @(posedge clk);
        #1;
        compared++;
        if (wr_en_s !== 1'b1 || busy_s !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset c16: got wr_en=%b busy=%b want 1 1", wr_en_s, busy_s);
        end
        #1 areset_n = 1'b0;
        #1;
        compared++;
        if ({rd_en_s, wr_en_s, busy_s, done_s, stage_s, wr_addr_a_s, wr_addr_b_s} !== 12'b0) begin
            mismatched++;
            $display("FAIL async_reset: got %h want 0",
                     {rd_en_s, wr_en_s, busy_s, done_s, stage_s, wr_addr_a_s, wr_addr_b_s});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        areset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            compared++;
            if ({wr_en_s, rd_en_s, busy_s, done_s} !== 4'b0) begin
                mismatched++;
                $display("FAIL post_reset_quiet c%0d: got %b want 0000", c, {wr_en_s, rd_en_s, busy_s, done_s});
            end
        end
    endtask

    task automatic test_full_size;
        int nrd = 0;
        int nwr = 0;
        int done_at = -1;
        int junk;
        build_model(10, 15);
        junk = $urandom_range(0, 7);
        repeat (junk) @(negedge clk);
        @(negedge clk);
        start_l = 1'b1;
        for (int c = 1; c <= model_done + 50 && done_at < 0; c++) begin
            @(negedge clk);
            start_l = ($urandom_range(0, 15) == 0);
            if (rd_en_l) begin
                compared++;
                if (nrd >= rd_q.size()) begin
                    mismatched++;
                    $display("FAIL big_rd_extra c%0d", c);
                end else if (rd_addr_a_l !== rd_q[nrd].a[9:0] || rd_addr_b_l !== rd_q[nrd].b[9:0] ||
                             tw_addr_l !== rd_q[nrd].tw[8:0] || c != rd_q[nrd].cyc) begin
                    mismatched++;
                    $display("FAIL big_rd #%0d c%0d: got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d c%0d",
                             nrd, c, rd_addr_a_l, rd_addr_b_l, tw_addr_l,
                             rd_q[nrd].a, rd_q[nrd].b, rd_q[nrd].tw, rd_q[nrd].cyc);
                end
                nrd++;
            end
            if (wr_en_l) begin
                compared++;
                if (nwr >= wr_q.size()) begin
                    mismatched++;
                    $display("FAIL big_wr_extra c%0d", c);
                end else if (wr_addr_a_l !== wr_q[nwr].a[9:0] || wr_addr_b_l !== wr_q[nwr].b[9:0] ||
                             c != wr_q[nwr].cyc) begin
                    mismatched++;
                    $display("FAIL big_wr #%0d c%0d: got a=%0d b=%0d want a=%0d b=%0d c%0d",
                             nwr, c, wr_addr_a_l, wr_addr_b_l, wr_q[nwr].a, wr_q[nwr].b, wr_q[nwr].cyc);
                end
                nwr++;
            end
            if (done_l) done_at = c;
        end
        start_l = 1'b0;
        compared++;
        if (nrd != 5120) begin
            mismatched++;
            $display("FAIL big_read_count: got %0d want 5120", nrd);
        end
        compared++;
        if (nwr != 5120) begin
            mismatched++;
            $display("FAIL big_write_count: got %0d want 5120", nwr);
        end
        compared++;
        if (done_at != model_done) begin
            mismatched++;
            $display("FAIL big_done_cycle: got %0d want %0d", done_at, model_done);
        end
    endtask

    initial begin
        test_reset;
        test_transform(12, 1);
        test_transform(28, 2);
        test_reset_mid_run;
        test_transform(-1, 1);
        test_full_size;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
